osc_meter: RTL and testbench
============================

# osc_meter

Synchronous measurement controller for the GPIO ring oscillator: it drives the oscillator's reset/halt controls, opens a counting window of a programmed number of system clocks, halts the ring, and safely reads the oscillator's free-running 32-bit edge counter back into the system clock domain. It sits between the oscillator instance (`osc`) and the register/readout logic. It is the reader/controller end of the `osc_rst` / `osc_halt` / `osc_counter` interface.

## Interface
- `GATE_W`, 24: width of `gate_cycles`.
- `RST_CYCLES`, 4: cycles `osc_rst` is held high in CLEAR, ≥1.
- `SETTLE_CYCLES`, 16: cycles waited after halting before sampling, ≥1.
- `MAX_TRIES`, 8: stability-compare attempts before `err`, ≥1.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `gate_cycles`  in  GATE_W  window length in `clk` cycles, latched on accepted `start`; 0 treated as 1.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `result`/`err` are updated.
- `result`  out  32  captured edge count, held until next `done`.
- `err`  out  1  set with `done` when no stable sample was obtained; `result` then holds the last sample.
- `osc_rst`  out  1  active-high clear to oscillator counter.
- `osc_halt`  out  1  1 = ring stopped (pad tristated), 0 = ring running.
- `osc_counter`  in  32  oscillator counter, asynchronous to `clk`.

## Operation
- Reset values: `busy`=0, `done`=0, `result`=0, `err`=0, `osc_rst`=1, `osc_halt`=1, FSM=IDLE. `osc_rst` falls on the first clock after reset release.
- FSM states:
  - IDLE: `osc_halt`=1, `osc_rst`=0. `start`=1 latches `gate_cycles` and enters CLEAR.
  - CLEAR: `osc_rst`=1 for exactly RST_CYCLES cycles, then RUN.
  - RUN: `osc_rst`=0, `osc_halt`=0 for exactly max(`gate_cycles`,1) cycles, then STOP.
  - STOP: `osc_halt`=1 for SETTLE_CYCLES cycles, then SAMPLE.
  - SAMPLE: `osc_counter` goes through a 2-flop synchronizer (all 32 bits, free-running in every state). Consecutive synchronized values are compared each cycle.
    - Equal: `result` ← value, `err`=0, go to DONE.
    - Unequal: increment the try counter. On reaching MAX_TRIES, `result` ← latest value, `err`=1, go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored and not queued. `gate_cycles` changes after acceptance have no effect.
- Counts are unsigned 32-bit. Oscillator-side wrap is not detected, so software sizes `gate_cycles`.
- Reset mid-operation aborts immediately to reset values. Any partial count is discarded.

## Timing
- `start` accepted at edge 0: CLEAR occupies edges 1..RST_CYCLES. RUN occupies the next G=max(`gate_cycles`,1) cycles, with `osc_halt` low for exactly G cycles.
- SAMPLE starts after STOP. The first compare is possible 2 cycles after entering SAMPLE (synchronizer fill), so the try counter starts counting only from that point.
- Minimum latency `start`→`done` = 1+RST_CYCLES+G+SETTLE_CYCLES+3 cycles. Each unstable compare adds 1 cycle.
- `result` and `err` update on the same edge `done` rises. `busy` falls the cycle after `done`.

## Structure
- Shared package `osc_pkg` holds:
  - FSM state enum (IDLE, CLEAR, RUN, STOP, SAMPLE, DONE);
  - `OSC_CNT_W`=32;
  - default parameter constants.
- One natural sub-module: `osc_cnt_sync`, the 32-bit 2-flop synchronizer plus stability comparator (outputs `stable`, `value`).
- FSM, gate counter, settle counter and try counter live in `osc_meter`.

## Test plan
- Bench model of `osc`: counter increments every 3 `clk` while halt=0, clears on `osc_rst`. Settings: RST_CYCLES=4, SETTLE_CYCLES=16, `gate_cycles`=300, `start` pulse. Required: `osc_rst` high 4 cycles, `osc_halt` low exactly 300 cycles, `done` at cycle 1+4+300+16+3=324, `result`=100, `err`=0.
- `gate_cycles`=0 → `osc_halt` low exactly 1 cycle; `result` ∈ {0,1}; `done` after 25 cycles.
- `start` pulsed again during RUN → ignored. Exactly one `done`; `gate_cycles` changed mid-run has no effect.
- Model keeps toggling `osc_counter` (e.g. +1 every clk) after halt, with MAX_TRIES=8 → `err`=1 with `done` after 8 failed compares; `result` = last sample.
- `rst_n` asserted during RUN → same cycle: `osc_halt`=1, `osc_rst`=1, `busy`=0, `result`=0. After release a new `start` produces a correct measurement.
- Back-to-back runs of 300 then 600 cycles → `result` 100 then 200. The counter is cleared between runs, not accumulated.

Source files
------------

// File: rtl/osc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | osc_pkg                                                              |
// | Shared types and defaults for the ring-oscillator measurement block. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package osc_pkg;

  localparam int OSC_CNT_W         = 32;
  localparam int DEF_GATE_W        = 24;
  localparam int DEF_RST_CYCLES    = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_MAX_TRIES     = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_STOP   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_DONE   = 3'd5
  } osc_state_e;

endpackage
`default_nettype wire

// File: rtl/osc_cnt_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | osc_cnt_sync                                                         |
// | Two-flop synchronizer for the oscillator count plus stability check. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module osc_cnt_sync
  import osc_pkg::*;
#(
  parameter int WIDTH = OSC_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] osc_counter,
  output logic             stable,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  // Bits may resolve on different cycles; two equal consecutive samples mean a coherent word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= osc_counter;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign stable = (r_sync2 == r_prev);
  assign value  = r_sync2;

endmodule
`default_nettype wire

// File: rtl/osc_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | osc_meter                                                            |
// | Gated ring-oscillator measurement controller with safe CDC readback. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module osc_meter
  import osc_pkg::*;
#(
  parameter int GATE_W        = DEF_GATE_W,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int MAX_TRIES     = DEF_MAX_TRIES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [GATE_W-1:0]    gate_cycles,
  output logic                 busy,
  output logic                 done,
  output logic [OSC_CNT_W-1:0] result,
  output logic                 err,
  output logic                 osc_rst,
  output logic                 osc_halt,
  input  logic [OSC_CNT_W-1:0] osc_counter
);

  localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

  osc_state_e           r_state;
  osc_state_e           w_state_next;
  logic [GATE_W-1:0]    r_gate;
  logic [GATE_W-1:0]    r_gate_cnt;
  logic [31:0]          r_settle_cnt;
  logic [c_TRY_W-1:0]   r_try;
  logic [OSC_CNT_W-1:0] r_result;
  logic                 r_err;
  logic                 r_osc_rst;
  logic                 r_osc_halt;

  logic                 w_stable;
  logic [OSC_CNT_W-1:0] w_value;
  logic [GATE_W-1:0]    w_gate_eff;
  logic                 w_fill_done;
  logic                 w_last_try;
  logic                 w_capture;

  osc_cnt_sync #(
    .WIDTH (OSC_CNT_W)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .osc_counter (osc_counter),
    .stable      (w_stable),
    .value       (w_value)
  );

  assign w_gate_eff  = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
  // The shared phase counter doubles as the synchronizer-fill delay inside SAMPLE.
  assign w_fill_done = (r_settle_cnt >= 32'd2);
  assign w_last_try  = (r_try == c_TRY_W'(MAX_TRIES - 1));
  assign w_capture   = (r_state == ST_SAMPLE) && w_fill_done && (w_stable || w_last_try);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_CLEAR;
      ST_CLEAR:  if (r_settle_cnt == 32'(RST_CYCLES - 1)) w_state_next = ST_RUN;
      ST_RUN:    if (r_gate_cnt == r_gate - GATE_W'(1)) w_state_next = ST_STOP;
      ST_STOP:   if (r_settle_cnt == 32'(SETTLE_CYCLES - 1)) w_state_next = ST_SAMPLE;
      ST_SAMPLE: if (w_capture) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate       <= GATE_W'(1);
      r_gate_cnt   <= '0;
      r_settle_cnt <= '0;
      r_try        <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_gate <= w_gate_eff;
      end
      r_gate_cnt   <= (r_state == ST_RUN && w_state_next == ST_RUN) ? r_gate_cnt + GATE_W'(1) : '0;
      r_settle_cnt <= (w_state_next == r_state) ? r_settle_cnt + 32'd1 : 32'd0;
      if (r_state == ST_SAMPLE) begin
        if (w_fill_done && !w_stable) begin
          r_try <= r_try + c_TRY_W'(1);
        end
      end else begin
        r_try <= '0;
      end
    end
  end

  // Oscillator controls are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result   <= '0;
      r_err      <= 1'b0;
      r_osc_rst  <= 1'b1;
      r_osc_halt <= 1'b1;
    end else begin
      if (w_capture) begin
        r_result <= w_value;
        r_err    <= !w_stable;
      end
      r_osc_rst  <= (w_state_next == ST_CLEAR);
      r_osc_halt <= (w_state_next != ST_RUN);
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign result   = r_result;
  assign err      = r_err;
  assign osc_rst  = r_osc_rst;
  assign osc_halt = r_osc_halt;

endmodule
`default_nettype wire

// File: tb/tb_osc_meter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_osc_meter                                                         |
// | Directed self-checking bench for osc_meter with a behavioural osc.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_osc_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] gate_cycles = 24'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic        osc_rst;
  logic        osc_halt;
  logic [31:0] osc_counter;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_cnt = 32'd0;
  int          m_div = 0;
  bit          m_toggle = 1'b0;

  osc_meter #(
    .GATE_W        (24),
    .RST_CYCLES    (4),
    .SETTLE_CYCLES (16),
    .MAX_TRIES     (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .gate_cycles (gate_cycles),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err),
    .osc_rst     (osc_rst),
    .osc_halt    (osc_halt),
    .osc_counter (osc_counter)
  );

  always #5 clk = ~clk;

  // Oscillator model: one count per 3 clocks while running, or +1 per clock in toggle mode.
  always @(negedge clk) begin
    if (osc_rst) begin
      m_cnt = 32'd0;
      m_div = 0;
    end else if (m_toggle) begin
      m_cnt = m_cnt + 32'd1;
    end else if (!osc_halt) begin
      if (m_div == 2) begin
        m_div = 0;
        m_cnt = m_cnt + 32'd1;
      end else begin
        m_div = m_div + 1;
      end
    end
  end
  assign osc_counter = m_cnt;

  // Start pulse in cycle 0; observe each following cycle 1ns after the edge.
  task automatic do_run(input logic [23:0] g, input int resend_at, input logic [23:0] g2,
                        output int lat, output int rst_hi, output int halt_lo, output int n_done,
                        output logic [31:0] res, output logic er, output logic bsy_after,
                        output logic bsy_end, output logic [31:0] m_at_done);
    lat = -1; rst_hi = 0; halt_lo = 0; n_done = 0;
    res = '0; er = 1'b0; bsy_after = 1'b1; m_at_done = '0;
    gate_cycles = g;
    start = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (resend_at != 0 && cyc == resend_at) begin start = 1'b1; gate_cycles = g2; end
      if (resend_at != 0 && cyc == resend_at + 1) start = 1'b0;
      if (osc_rst) rst_hi++;
      if (!osc_halt) halt_lo++;
      if (lat >= 0 && cyc == lat + 1) bsy_after = busy;
      if (done) begin
        n_done++;
        if (lat < 0) begin lat = cyc; res = result; er = err; m_at_done = m_cnt; end
      end
      if (lat >= 0 && cyc >= lat + 20) break;
    end
    bsy_end = busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL reset_result got %0d want 0", result); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else n_pass++;
    n_checks++; if (osc_rst !== 1'b1) $display("FAIL reset_osc_rst got %b want 1", osc_rst); else n_pass++;
    n_checks++; if (osc_halt !== 1'b1) $display("FAIL reset_osc_halt got %b want 1", osc_halt); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (osc_rst !== 1'b0) $display("FAIL release_osc_rst got %b want 0", osc_rst); else n_pass++;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    do_run(24'd300, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (rh != 4) $display("FAIL basic_rst_cycles got %0d want 4", rh); else n_pass++;
    n_checks++; if (hl != 300) $display("FAIL basic_halt_low got %0d want 300", hl); else n_pass++;
    n_checks++; if (lat != 324) $display("FAIL basic_latency got %0d want 324", lat); else n_pass++;
    n_checks++; if (res !== 32'd100) $display("FAIL basic_result got %0d want 100", res); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL basic_err got %b want 0", er); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL basic_done_count got %0d want 1", nd); else n_pass++;
    n_checks++; if (ba !== 1'b0) $display("FAIL basic_busy_after_done got %b want 0", ba); else n_pass++;
  endtask

  task automatic test_gate_zero();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    do_run(24'd0, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (hl != 1) $display("FAIL gate0_halt_low got %0d want 1", hl); else n_pass++;
    n_checks++; if (lat != 25) $display("FAIL gate0_latency got %0d want 25", lat); else n_pass++;
    n_checks++; if (res > 32'd1) $display("FAIL gate0_result got %0d want 0 or 1", res); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL gate0_err got %b want 0", er); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    do_run(24'd300, 100, 24'd50, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (nd != 1) $display("FAIL ignore_done_count got %0d want 1", nd); else n_pass++;
    n_checks++; if (lat != 324) $display("FAIL ignore_latency got %0d want 324", lat); else n_pass++;
    n_checks++; if (res !== 32'd100) $display("FAIL ignore_result got %0d want 100", res); else n_pass++;
    n_checks++; if (be !== 1'b0) $display("FAIL ignore_busy_end got %b want 0", be); else n_pass++;
  endtask

  task automatic test_unstable();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    m_toggle = 1'b1;
    do_run(24'd10, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    m_toggle = 1'b0;
    n_checks++; if (er !== 1'b1) $display("FAIL unstable_err got %b want 1", er); else n_pass++;
    n_checks++; if (lat != 41) $display("FAIL unstable_latency got %0d want 41", lat); else n_pass++;
    n_checks++; if (res !== m - 32'd2) $display("FAIL unstable_result got %0d want %0d", res, m - 32'd2); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    gate_cycles = 24'd300;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    n_checks++; if (osc_halt !== 1'b0) $display("FAIL midrst_precond_halt got %b want 0", osc_halt); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (osc_halt !== 1'b1) $display("FAIL midrst_osc_halt got %b want 1", osc_halt); else n_pass++;
    n_checks++; if (osc_rst !== 1'b1) $display("FAIL midrst_osc_rst got %b want 1", osc_rst); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (result !== 32'd0) $display("FAIL midrst_result got %0d want 0", result); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (osc_rst !== 1'b0) $display("FAIL midrst_release_osc_rst got %b want 0", osc_rst); else n_pass++;
    repeat (2) @(posedge clk); #1;
    do_run(24'd300, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (res !== 32'd100) $display("FAIL midrst_rerun_result got %0d want 100", res); else n_pass++;
    n_checks++; if (lat != 324) $display("FAIL midrst_rerun_latency got %0d want 324", lat); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, rh, hl, nd; logic [31:0] res, m; logic er, ba, be;
    do_run(24'd300, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (res !== 32'd100) $display("FAIL b2b_first_result got %0d want 100", res); else n_pass++;
    do_run(24'd600, 0, 24'd0, lat, rh, hl, nd, res, er, ba, be, m);
    n_checks++; if (res !== 32'd200) $display("FAIL b2b_second_result got %0d want 200", res); else n_pass++;
    n_checks++; if (lat != 624) $display("FAIL b2b_second_latency got %0d want 624", lat); else n_pass++;
    n_checks++; if (hl != 600) $display("FAIL b2b_second_halt_low got %0d want 600", hl); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gate_zero();
    test_ignore_start();
    test_unstable();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
